// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;
    localparam int RF_NRD_DEF   = 2;

endpackage

// File: rtl/regfile_if.sv
// Bus bundle of regfile_sb: read ports, writeback, issue, debug tap and ready.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NRD   = RF_NRD_DEF
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                ready;
    logic [AW-1:0]       dbg_sel;
    logic [XLEN-1:0]     dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, dbg_sel,
        input  rd_data, rd_busy, ready, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, dbg_sel,
        output rd_data, rd_busy, ready, dbg_data
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: sweep clear, issue/writeback update and per-port busy reads.
// Honours REGFILE_BYPASS_EN: a same-cycle writeback hides the busy bit of its register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NRD   = RF_NRD_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic              i_clr_en,
    input  logic [AW-1:0]     i_clr_idx,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic              i_iss_en,
    input  logic [AW-1:0]     i_iss_rd,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_rd_busy
);

    logic [NREGS-1:0] r_busy;

    // Busy bit update; the issue is applied last so a new producer wins over a writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= r_busy;
        end else if (i_clr_en) begin
            r_busy[i_clr_idx] <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_busy[i_wr_addr] <= 1'b0;
            end
            if (i_iss_en) begin
                r_busy[i_iss_rd] <= 1'b1;
            end
        end
    end

    // Per-port busy lookup; address 0 and the clear sweep always read not-busy.
    always_comb begin
        o_rd_busy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            if (!i_run || (i_rd_addr[i*AW +: AW] == {AW{1'b0}})) begin
                o_rd_busy[i] = 1'b0;
`ifdef REGFILE_BYPASS_EN
            end else if (i_wr_en && (i_rd_addr[i*AW +: AW] == i_wr_addr)) begin
                o_rd_busy[i] = 1'b0;
`endif
            end else begin
                o_rd_busy[i] = r_busy[i_rd_addr[i*AW +: AW]];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard and a post-reset clear sweep.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NRD   = RF_NRD_DEF
) (
    input  logic      clk,
    input  logic      reset,
    regfile_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    rf_state_e       r_state;
    rf_state_e       w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic            r_ready;
    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_run;
    logic            w_clr;
    logic            w_wr_ok;
    logic            w_iss_ok;
    logic [NRD*XLEN-1:0] w_rd_data;
    logic [NRD-1:0]      w_rd_busy;

    assign w_run    = (r_state == RF_RUN);
    assign w_clr    = (r_state == RF_CLEAR);
    assign w_wr_ok  = w_run && bus.wr_en  && (bus.wr_addr != {AW{1'b0}});
    assign w_iss_ok = w_run && bus.iss_en && (bus.iss_rd  != {AW{1'b0}});

    // Next-state logic: the sweep ends after the last register has been cleared.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RF_CLEAR: begin
                if (r_cnt == AW'(NREGS - 1)) begin
                    w_state_nxt = RF_RUN;
                end else begin
                    w_state_nxt = RF_CLEAR;
                end
            end
            RF_RUN:   w_state_nxt = RF_RUN;
            default:  w_state_nxt = RF_CLEAR;
        endcase
    end

    // State, sweep counter and ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RF_CLEAR;
            r_cnt   <= {AW{1'b0}};
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == RF_RUN);
            if (w_clr) begin
                r_cnt <= r_cnt + AW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Data array: zeroed one entry per cycle by the sweep, then written back in RUN.
    always_ff @(posedge clk) begin
        if (!reset && w_clr) begin
            r_regs[r_cnt] <= {XLEN{1'b0}};
        end else if (!reset && w_wr_ok) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read data muxes; all ports are independent copies of the same lookup.
    always_comb begin
        w_rd_data = {(NRD*XLEN){1'b0}};
        for (int i = 0; i < NRD; i++) begin
            if (!w_run || (bus.rd_addr[i*AW +: AW] == {AW{1'b0}})) begin
                w_rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
            end else if (w_wr_ok && (bus.rd_addr[i*AW +: AW] == bus.wr_addr)) begin
                w_rd_data[i*XLEN +: XLEN] = bus.wr_data;
`endif
            end else begin
                w_rd_data[i*XLEN +: XLEN] = r_regs[bus.rd_addr[i*AW +: AW]];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .i_run     (w_run),
        .i_clr_en  (w_clr),
        .i_clr_idx (r_cnt),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (bus.wr_addr),
        .i_iss_en  (w_iss_ok),
        .i_iss_rd  (bus.iss_rd),
        .i_rd_addr (bus.rd_addr),
        .o_rd_busy (w_rd_busy)
    );

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_busy  = w_rd_busy;
    assign bus.ready    = r_ready;
    assign bus.dbg_data = w_run ? r_regs[bus.dbg_sel] : {XLEN{1'b0}};

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, register width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, 2..64; AW = $clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of independent read ports, 1..4.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rd_addr  in  NRD*AW  packed read addresses, port i in slice i.
REQ-007 rd_data  out  NRD*XLEN  packed read data, port i in slice i.
REQ-008 rd_busy  out  NRD  per-port busy flag of the addressed register.
REQ-009 wr_en, wr_addr, wr_data  in  1, AW, XLEN  writeback port.
REQ-010 iss_en, iss_rd  in  1, AW  issue port; marks destination register busy.
REQ-011 ready  out  1  high once the post-reset clear sweep has completed.
REQ-012 dbg_sel, dbg_data  in AW / out XLEN  debug tap; dbg_data = reg[dbg_sel], no bypass.

Function
REQ-013 Two-state FSM: CLEAR and RUN; reset forces CLEAR with sweep counter = 0.
REQ-014 CLEAR: each cycle writes 0 to reg[cnt] and clears busy[cnt]; cnt increments; at cnt == NREGS-1 the next state is RUN.
REQ-015 Sweep lasts exactly NREGS cycles; ready rises on the first RUN cycle and stays high until the next reset.
REQ-016 During CLEAR, wr_en and iss_en are ignored; rd_data, rd_busy and dbg_data read 0.
REQ-017 Reads are combinational: rd_data[i] = reg[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]].
REQ-018 Register 0 always reads 0 and is never busy; writes and issues to address 0 are discarded.
REQ-019 Write: when wr_en in RUN and wr_addr != 0, reg[wr_addr] updates at the rising edge and busy[wr_addr] clears.
REQ-020 Issue: when iss_en in RUN and iss_rd != 0, busy[iss_rd] sets at the rising edge.
REQ-021 Same-cycle issue and write to the same register: data is written and busy ends set (new producer wins).
REQ-022 Issue to an already-busy register keeps it busy; a write to a non-busy register still updates data.
REQ-023 All read ports are independent; identical addresses on several ports return identical results.

Reset
REQ-024 Reset asserted in any state, including mid-sweep, restarts the sweep at cnt = 0 and drives ready low on the next cycle.
REQ-025 Reset values: ready = 0, state = CLEAR, cnt = 0; registers reach 0 only through the sweep.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: in RUN, a port with rd_addr[i] == wr_addr != 0 and wr_en high returns wr_data and rd_busy[i] = 0 in the same cycle; iss_en on that register in the same cycle does not affect rd_busy.
REQ-027 REGFILE_BYPASS_EN undefined: no forwarding; reads reflect register state before the edge.

Structure
REQ-028 Package regfile_pkg holds the FSM state enum (RF_CLEAR, RF_RUN) and default XLEN/NREGS constants.
REQ-029 Busy-bit array, issue/clear logic and the busy read muxes form sub-module regfile_scoreboard.

Verification
REQ-030 Reset for 1 cycle, NREGS=32 -> ready low for exactly 32 cycles; every register and dbg_data read 0 afterwards.
REQ-031 Write 0xDEADBEEF to r5, then read r5 on both ports -> 0xDEADBEEF on both; write to r0 -> r0 still 0.
REQ-032 Issue r7, then write r7 = 0x12 three cycles later -> rd_busy high for 3 cycles, then low with data 0x12.
REQ-033 Same cycle iss_rd = 9, wr_addr = 9, wr_data = 0x55 -> r9 = 0x55 and busy[9] = 1.
REQ-034 With REGFILE_BYPASS_EN: r3 = 1, write r3 = 0xAA and read r3 in the same cycle -> 0xAA, busy 0; without it -> 1.
REQ-035 Reset at cycle 10 of the sweep -> sweep restarts, ready rises 32 cycles after reset deasserts, and writes during CLEAR are lost.
